load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the RISC-V execute stage and the word-addressed data memory (ports RW, EN, ADDr, Din, Dout, CLK; combinational read; write on posedge when EN=1 and RW=1).
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW, including byte-lane extraction, sign/zero extension and read-modify-write for sub-word stores.
- Flags out-of-range and illegal-funct3 requests.
- Uses a valid/ready request handshake and a one-cycle DONE pulse toward the core.

Parameters:
- MEM_WORDS, 2001, number of 32-bit words in the data memory; valid word index is 0..MEM_WORDS-1.

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  unit can accept a request
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data (low bits used for B/H)
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; request rejected, no memory write
- RDATA  out  32  load result, valid with DONE, held until next DONE
- MEM_EN  out  1  to memory EN
- MEM_RW  out  1  to memory RW (1 = write)
- MEM_ADDr  out  32  to memory ADDr, always {addr[31:2],2'b00}
- MEM_Din  out  32  to memory Din
- MEM_Dout  in  32  from memory Dout

Behaviour:
- Reset: state=IDLE; DONE=0, ERR=0, RDATA=0, MEM_EN=0, MEM_RW=0, MEM_ADDr=0, MEM_Din=0.
- While RST=1, MEM_EN is forced to 0 combinationally, so no write commits in a reset cycle.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- REQ_READY=1 only in IDLE; accept on edge with REQ_VALID&&REQ_READY; request registered at accept.
- Illegal request, checked at accept: no memory access, DONE=ERR=1 in the next cycle, stay IDLE, RDATA unchanged. A request is illegal if any of these holds:
  - addr[31:2] >= MEM_WORDS
  - load funct3 in {011,110,111}
  - store funct3 not in {000,001,010}
- Legal load: IDLE -> LOAD. In LOAD: MEM_EN=1, MEM_RW=0.
  - At the edge, RDATA <= lane-extracted MEM_Dout. Lanes are little-endian: byte k = bits 8k+7:8k; halfword selected by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended.
  - Return to IDLE; DONE high the following cycle.
  - Latency: accept edge to DONE = 2 edges.
- SW: IDLE -> STORE. MEM_EN=1, MEM_RW=1, MEM_Din=WDATA; memory writes at the edge; -> IDLE; DONE next cycle.
- SB/SH: IDLE -> RMW_RD -> RMW_WR -> IDLE.
  - RMW_RD: MEM_EN=1, MEM_RW=0; word captured at the edge.
  - RMW_WR: MEM_EN=1, MEM_RW=1, MEM_Din = captured word with the selected lane(s) replaced by WDATA[7:0] / WDATA[15:0].
  - Latency: 3 edges accept-to-DONE.
- In IDLE: MEM_EN=0, MEM_RW=0, MEM_Din=0. MEM_ADDr keeps the last aligned address (0 after reset).
- A new request can be accepted in the same cycle DONE is high (back-to-back).
- RST in any state aborts to IDLE; no DONE for the aborted request.
- ERR=0 whenever DONE=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned access (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) is treated as illegal: DONE=ERR=1 next cycle, no access.
- Undefined: low address bits beyond the access size are ignored.
  - H uses addr[1] only.
  - W uses the aligned word.
  - The access proceeds normally with ERR=0.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF -> MEM_EN/MEM_RW=1 for one cycle, DONE 2 edges after accept; LW 0x10 -> RDATA=0xDEADBEEF, ERR=0.
- SB addr 0x11 data 0x000000A5 over word 0xDEADBEEF -> RMW read then write of 0xDEADA5EF; LB 0x11 -> RDATA=0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
- SH addr 0x12 data 0x1234 -> word becomes 0x1234A5EF; LH 0x12 -> 0x00001234; LHU 0x10 -> 0x0000A5EF; LH 0x10 -> 0xFFFFA5EF.
- Illegal requests, each -> DONE=ERR=1 next cycle with MEM_EN never asserted:
  - LW at word index 2001 (addr 0x1F44)
  - load funct3=011
  - store funct3=100
- LW addr 0x13: with LSU_MISALIGN_TRAP_EN -> ERR=1, no access; without it -> reads word 0x10, ERR=0.
- RST asserted during RMW_WR of SB 0x20 -> MEM_EN=0 that cycle, word 0x20 unchanged, no DONE, REQ_READY=1 after reset. Back-to-back SW then LW with REQ_VALID held -> second request accepted in the DONE cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the RISC-V execute stage and a word-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/SH/W/SW requests are rejected with ERR.
module load_store_unit #(
  parameter int MEM_WORDS = 2001
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        MEM_EN,
  output logic        MEM_RW,
  output logic [31:0] MEM_ADDr,
  output logic [31:0] MEM_Din,
  input  logic [31:0] MEM_Dout,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where REQ_VALID && REQ_READY;
  // REQ_READY is high only in IDLE and DONE/ERR/RDATA answer it as a one-cycle pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  state_t      state, state_nxt;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;
  logic [31:0] rmw_word;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        accept;
  logic        illegal;

  assign accept    = REQ_VALID && REQ_READY;
  assign dbg_state = state;

  always_comb begin
    illegal = 1'b0;
    if ({2'b00, REQ_ADDR[31:2]} >= MEM_WORDS_U) illegal = 1'b1;
    if (!REQ_WE && (REQ_FUNCT3 inside {3'b011, 3'b110, 3'b111})) illegal = 1'b1;
    if (REQ_WE && !(REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010})) illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) illegal = 1'b1;
    if ((REQ_FUNCT3 == 3'b010) && (REQ_ADDR[1:0] != 2'b00)) illegal = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          if (!REQ_WE)                   state_nxt = LOAD;
          else if (REQ_FUNCT3 == 3'b010) state_nxt = STORE;
          else                           state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = IDLE;
      STORE:   state_nxt = IDLE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction: byte lane from addr[1:0], halfword lane from addr[1] only.
  always_comb begin
    byte_v = MEM_Dout[{lane_r, 3'b000} +: 8];
    half_v = MEM_Dout[{lane_r[1], 4'b0000} +: 16];
    case (f3_r)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = MEM_Dout;
    endcase
  end

  always_comb begin
    merged = rmw_word;
    if (f3_r[0] == 1'b0) merged[{lane_r, 3'b000} +: 8]     = wdata_r[7:0];
    else                 merged[{lane_r[1], 4'b0000} +: 16] = wdata_r[15:0];
  end

  always_comb begin
    REQ_READY = (state == IDLE);
    MEM_EN    = 1'b0;
    MEM_RW    = 1'b0;
    MEM_Din   = 32'h0;
    case (state)
      LOAD:   MEM_EN = 1'b1;
      STORE:  begin MEM_EN = 1'b1; MEM_RW = 1'b1; MEM_Din = wdata_r; end
      RMW_RD: MEM_EN = 1'b1;
      RMW_WR: begin MEM_EN = 1'b1; MEM_RW = 1'b1; MEM_Din = merged; end
      default: ;
    endcase
    // A reset cycle must never commit a write, even mid read-modify-write.
    if (RST) MEM_EN = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RDATA    <= 32'h0;
      MEM_ADDr <= 32'h0;
      f3_r     <= 3'b000;
      lane_r   <= 2'b00;
      wdata_r  <= 32'h0;
      rmw_word <= 32'h0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      if (accept) begin
        if (illegal) begin
          DONE <= 1'b1;
          ERR  <= 1'b1;
        end else begin
          f3_r     <= REQ_FUNCT3;
          lane_r   <= REQ_ADDR[1:0];
          wdata_r  <= REQ_WDATA;
          MEM_ADDr <= {REQ_ADDR[31:2], 2'b00};
        end
      end
      case (state)
        LOAD: begin
          RDATA <= load_val;
          DONE  <= 1'b1;
        end
        STORE:   DONE <= 1'b1;
        RMW_RD:  rmw_word <= MEM_Dout;
        RMW_WR:  DONE <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected {latency, err, rdata};
// a negedge monitor pops and compares on every DONE pulse.
module tb_load_store_unit;

  localparam int MEM_WORDS = 2001;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = 3'b000;
  logic [31:0] REQ_ADDR = 32'h0;
  logic [31:0] REQ_WDATA = 32'h0;
  logic        DONE, ERR;
  logic [31:0] RDATA;
  logic        MEM_EN, MEM_RW;
  logic [31:0] MEM_ADDr, MEM_Din, MEM_Dout;
  logic [2:0]  dbg_state;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW),
    .MEM_ADDr(MEM_ADDr), .MEM_Din(MEM_Din), .MEM_Dout(MEM_Dout), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // data memory model: combinational read, write on posedge with EN && RW
  logic [31:0] mem [0:MEM_WORDS-1] = '{default: 32'h0};
  logic        in_range;
  logic [10:0] midx;
  assign in_range = (MEM_ADDr[31:2] < 30'd2001);
  assign midx     = MEM_ADDr[12:2];
  assign MEM_Dout = in_range ? mem[midx] : 32'h0;
  always @(posedge CLK) if (MEM_EN && MEM_RW && in_range) mem[midx] <= MEM_Din;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int wr_cycles = 0;
  int err_wo_done = 0;
  logic [31:0] last_rd = 32'h0;
  logic [36:0] exp_q[$];
  int          acc_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [36:0] e;
    int          a;
    if (MEM_EN) en_cycles++;
    if (MEM_EN && MEM_RW) wr_cycles++;
    if (ERR && !DONE) err_wo_done++;
    if (DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("done_err", {31'h0, ERR}, {31'h0, e[32]});
        check("done_rdata", RDATA, e[31:0]);
        check("done_latency", 32'(cyc - a), {28'h0, e[36:33]});
      end
    end
  end

  // driver: present a request from a negedge, hold until accepted
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input logic [3:0] lat, input logic push, output logic done_at_acc);
    int g = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
    while (!REQ_READY && g < 50) begin
      @(negedge CLK);
      g++;
    end
    if (!REQ_READY) check("accept_timeout", 32'd0, 32'd1);
    done_at_acc = DONE;
    if (push) begin
      if (!we && !e_err) last_rd = e_rd;
      exp_q.push_back({lat, e_err, last_rd});
      acc_q.push_back(cyc);
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                     input logic [3:0] lat);
    logic d;
    issue(we, f3, addr, wd, e_err, e_rd, lat, 1'b1, d);
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge CLK);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    int  e0, w0;
    logic d;
    repeat (3) @(negedge CLK);
    check("rst_mem_en", {31'h0, MEM_EN}, 32'd0);
    RST = 1'b0;
    #1;
    check("rst_done", {31'h0, DONE}, 32'd0);
    check("rst_err", {31'h0, ERR}, 32'd0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_mem_addr", MEM_ADDr, 32'h0);
    check("rst_mem_din", MEM_Din, 32'h0);
    check("rst_mem_rw", {31'h0, MEM_RW}, 32'd0);
    check("rst_ready", {31'h0, REQ_READY}, 32'd1);

    // word store then load
    e0 = en_cycles; w0 = wr_cycles;
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4'd2);
    wait_done();
    check("sw_en_cycles", 32'(en_cycles - e0), 32'd1);
    check("sw_wr_cycles", 32'(wr_cycles - w0), 32'd1);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4'd2);

    // byte store via read-modify-write
    wait_done();
    e0 = en_cycles; w0 = wr_cycles;
    req(1'b1, 3'b000, 32'h11, 32'h000000A5, 1'b0, 32'h0, 4'd3);
    wait_done();
    check("sb_en_cycles", 32'(en_cycles - e0), 32'd2);
    check("sb_wr_cycles", 32'(wr_cycles - w0), 32'd1);
    check("sb_mem", mem[4], 32'hDEADA5EF);
    req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFA5, 4'd2);
    req(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000A5, 4'd2);
    req(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 4'd2);

    // halfword store and loads
    req(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0, 32'h0, 4'd3);
    wait_done();
    check("sh_mem", mem[4], 32'h1234A5EF);
    req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'h00001234, 4'd2);
    req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000A5EF, 4'd2);
    req(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFA5EF, 4'd2);
    req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'h00000012, 4'd2);
    wait_done();

    // illegal requests never touch memory
    e0 = en_cycles;
    req(1'b0, 3'b010, 32'h1F44, 32'h0, 1'b1, 32'h0, 4'd1);
    req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 4'd1);
    req(1'b1, 3'b100, 32'h10, 32'h55555555, 1'b1, 32'h0, 4'd1);
    wait_done();
    check("illegal_en_cycles", 32'(en_cycles - e0), 32'd0);
    check("illegal_mem", mem[4], 32'h1234A5EF);
    req(1'b0, 3'b010, 32'h1F40, 32'h0, 1'b0, 32'h0, 4'd2);
    wait_done();

    // misaligned word load
    e0 = en_cycles;
`ifdef LSU_MISALIGN_TRAP_EN
    req(1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 32'h0, 4'd1);
    wait_done();
    check("misalign_en_cycles", 32'(en_cycles - e0), 32'd0);
`else
    req(1'b0, 3'b010, 32'h13, 32'h0, 1'b0, 32'h1234A5EF, 4'd2);
    wait_done();
    check("misalign_en_cycles", 32'(en_cycles - e0), 32'd1);
`endif

    // reset during RMW_WR aborts the byte store
    req(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'h0, 4'd2);
    wait_done();
    issue(1'b1, 3'b000, 32'h20, 32'h00000077, 1'b0, 32'h0, 4'd3, 1'b0, d);
    @(posedge CLK);
    @(negedge CLK);
    check("abort_state_rmw_wr", {29'h0, dbg_state}, 32'd4);
    RST = 1'b1;
    #1;
    check("abort_mem_en", {31'h0, MEM_EN}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    last_rd = 32'h0;
    check("abort_ready", {31'h0, REQ_READY}, 32'd1);
    check("abort_rdata", RDATA, 32'h0);
    repeat (3) @(negedge CLK);
    check("abort_mem", mem[8], 32'h11223344);

    // back-to-back: second request accepted in the DONE cycle of the first
    issue(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 4'd2, 1'b1, d);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D, 4'd2, 1'b1, d);
    check("b2b_accept_in_done", {31'h0, d}, 32'd1);
    wait_done();

    check("err_without_done", 32'(err_wo_done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
